// File: rtl/attitude_pkg.sv
// Shared types and constants for the attitude peripheral: feeder FSM states and IMU axis indices.
package attitude_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWaitQ = 2'd2
  } feeder_state_t;

  localparam logic [2:0] AXIS_AX = 3'd0;
  localparam logic [2:0] AXIS_AY = 3'd1;
  localparam logic [2:0] AXIS_AZ = 3'd2;
  localparam logic [2:0] AXIS_WX = 3'd3;
  localparam logic [2:0] AXIS_WY = 3'd4;
  localparam logic [2:0] AXIS_WZ = 3'd5;

  localparam logic [5:0] AXIS_ALL = 6'b111111;

endpackage

// File: rtl/imu_sample_capture.sv
// Six-axis capture buffer: one register per axis plus a received mask; full once every axis is seen.
module imu_sample_capture
  import attitude_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned GYRO_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [2:0]        s_axis_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              take_i,
  output logic              cap_full_o,
  output logic [ACC_W-1:0]  cap_a_x_o,
  output logic [ACC_W-1:0]  cap_a_y_o,
  output logic [ACC_W-1:0]  cap_a_z_o,
  output logic [GYRO_W-1:0] cap_w_x_o,
  output logic [GYRO_W-1:0] cap_w_y_o,
  output logic [GYRO_W-1:0] cap_w_z_o
);

  logic [5:0]        mask_q, mask_d;
  logic [ACC_W-1:0]  a_x_q, a_x_d, a_y_q, a_y_d, a_z_q, a_z_d;
  logic [GYRO_W-1:0] w_x_q, w_x_d, w_y_q, w_y_d, w_z_q, w_z_d;
  logic              accept;

  assign cap_full_o = (mask_q == AXIS_ALL);
  assign s_ready_o  = !cap_full_o;
  assign accept     = s_valid_i && s_ready_o;

  always_comb begin
    mask_d = mask_q;
    a_x_d  = a_x_q;
    a_y_d  = a_y_q;
    a_z_d  = a_z_q;
    w_x_d  = w_x_q;
    w_y_d  = w_y_q;
    w_z_d  = w_z_q;
    if (take_i) begin
      mask_d = '0;
    end else if (accept) begin
      // Indices 6 and 7 match no bit and fall through the case: accepted but dropped.
      for (int i = 0; i < 6; i++) begin
        if (s_axis_i == 3'(i)) mask_d[i] = 1'b1;
      end
      case (s_axis_i)
        AXIS_AX: a_x_d = s_data_i[ACC_W-1:0];
        AXIS_AY: a_y_d = s_data_i[ACC_W-1:0];
        AXIS_AZ: a_z_d = s_data_i[ACC_W-1:0];
        AXIS_WX: w_x_d = s_data_i[GYRO_W-1:0];
        AXIS_WY: w_y_d = s_data_i[GYRO_W-1:0];
        AXIS_WZ: w_z_d = s_data_i[GYRO_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      a_x_q  <= '0;
      a_y_q  <= '0;
      a_z_q  <= '0;
      w_x_q  <= '0;
      w_y_q  <= '0;
      w_z_q  <= '0;
    end else begin
      mask_q <= mask_d;
      a_x_q  <= a_x_d;
      a_y_q  <= a_y_d;
      a_z_q  <= a_z_d;
      w_x_q  <= w_x_d;
      w_y_q  <= w_y_d;
      w_z_q  <= w_z_d;
    end
  end

  assign cap_a_x_o = a_x_q;
  assign cap_a_y_o = a_y_q;
  assign cap_a_z_o = a_z_q;
  assign cap_w_x_o = w_x_q;
  assign cap_w_y_o = w_y_q;
  assign cap_w_z_o = w_z_q;

endmodule

// File: rtl/imu_sample_feeder.sv
// Feeds complete IMU samples into the madgwick filter and latches the returned quaternion,
// with new-data, overrun and sample-count status for the register interface.
module imu_sample_feeder
  import attitude_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned GYRO_W = 16,
  parameter int unsigned Q_W    = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2:0]        s_axis,
  input  logic [DATA_W-1:0] s_data,
  output logic              filt_valid_in,
  input  logic              filt_ready_in,
  output logic [ACC_W-1:0]  filt_a_x,
  output logic [ACC_W-1:0]  filt_a_y,
  output logic [ACC_W-1:0]  filt_a_z,
  output logic [GYRO_W-1:0] filt_w_x,
  output logic [GYRO_W-1:0] filt_w_y,
  output logic [GYRO_W-1:0] filt_w_z,
  input  logic              filt_valid_out,
  output logic              filt_ready_out,
  input  logic [Q_W-1:0]    filt_q_w,
  input  logic [Q_W-1:0]    filt_q_x,
  input  logic [Q_W-1:0]    filt_q_y,
  input  logic [Q_W-1:0]    filt_q_z,
  output logic [Q_W-1:0]    q_w,
  output logic [Q_W-1:0]    q_x,
  output logic [Q_W-1:0]    q_y,
  output logic [Q_W-1:0]    q_z,
  output logic              q_new,
  input  logic              q_ack,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic [CNT_W-1:0]  sample_cnt
);

  feeder_state_t     state_q, state_d;
  logic              cap_full, take, latch;
  logic [ACC_W-1:0]  cap_a_x, cap_a_y, cap_a_z;
  logic [GYRO_W-1:0] cap_w_x, cap_w_y, cap_w_z;
  logic [ACC_W-1:0]  a_x_q, a_y_q, a_z_q;
  logic [GYRO_W-1:0] w_x_q, w_y_q, w_z_q;
  logic [Q_W-1:0]    q_w_q, q_x_q, q_y_q, q_z_q;
  logic              q_new_q, q_new_d, ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  imu_sample_capture #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .GYRO_W (GYRO_W)
  ) u_capture (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_axis_i   (s_axis),
    .s_data_i   (s_data),
    .take_i     (take),
    .cap_full_o (cap_full),
    .cap_a_x_o  (cap_a_x),
    .cap_a_y_o  (cap_a_y),
    .cap_a_z_o  (cap_a_z),
    .cap_w_x_o  (cap_w_x),
    .cap_w_y_o  (cap_w_y),
    .cap_w_z_o  (cap_w_z)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    latch   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cap_full && enable) begin
          take    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (filt_ready_in) state_d = StWaitQ;
      end
      StWaitQ: begin
        if (filt_valid_out) begin
          latch   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A latch always wins over a same-cycle ack or clear; an ack in the latch cycle suppresses overrun.
  always_comb begin
    q_new_d = q_new_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (latch) begin
      q_new_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end else if (q_ack) begin
      q_new_d = 1'b0;
    end
    if (latch && q_new_q && !q_ack) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_x_q   <= '0;
      a_y_q   <= '0;
      a_z_q   <= '0;
      w_x_q   <= '0;
      w_y_q   <= '0;
      w_z_q   <= '0;
      q_w_q   <= '0;
      q_x_q   <= '0;
      q_y_q   <= '0;
      q_z_q   <= '0;
      q_new_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        a_x_q <= cap_a_x;
        a_y_q <= cap_a_y;
        a_z_q <= cap_a_z;
        w_x_q <= cap_w_x;
        w_y_q <= cap_w_y;
        w_z_q <= cap_w_z;
      end
      if (latch) begin
        q_w_q <= filt_q_w;
        q_x_q <= filt_q_x;
        q_y_q <= filt_q_y;
        q_z_q <= filt_q_z;
      end
      q_new_q <= q_new_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_valid_in  = (state_q == StIssue);
  assign filt_ready_out = (state_q == StWaitQ);
  assign filt_a_x       = a_x_q;
  assign filt_a_y       = a_y_q;
  assign filt_a_z       = a_z_q;
  assign filt_w_x       = w_x_q;
  assign filt_w_y       = w_y_q;
  assign filt_w_z       = w_z_q;
  assign q_w            = q_w_q;
  assign q_x            = q_x_q;
  assign q_y            = q_y_q;
  assign q_z            = q_z_q;
  assign q_new          = q_new_q;
  assign overrun        = ovr_q;
  assign sample_cnt     = cnt_q;

endmodule

// File: tb/tb_imu_sample_feeder.sv
// Randomised and directed bench for imu_sample_feeder against a transaction-level reference model.
module tb_imu_sample_feeder;

  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [2:0]        s_axis = '0;
  logic [15:0]       s_data = '0;
  logic              filt_valid_in;
  logic              filt_ready_in = 1'b0;
  logic [15:0]       filt_a_x, filt_a_y, filt_a_z, filt_w_x, filt_w_y, filt_w_z;
  logic              filt_valid_out = 1'b0;
  logic              filt_ready_out;
  logic [15:0]       filt_q_w = '0, filt_q_x = '0, filt_q_y = '0, filt_q_z = '0;
  logic [15:0]       q_w, q_x, q_y, q_z;
  logic              q_new;
  logic              q_ack = 1'b0;
  logic              overrun;
  logic              ovr_clr = 1'b0;
  logic [CNT_W-1:0]  sample_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  imu_sample_feeder #(
    .DATA_W (16),
    .ACC_W  (16),
    .GYRO_W (16),
    .Q_W    (16),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_axis         (s_axis),
    .s_data         (s_data),
    .filt_valid_in  (filt_valid_in),
    .filt_ready_in  (filt_ready_in),
    .filt_a_x       (filt_a_x),
    .filt_a_y       (filt_a_y),
    .filt_a_z       (filt_a_z),
    .filt_w_x       (filt_w_x),
    .filt_w_y       (filt_w_y),
    .filt_w_z       (filt_w_z),
    .filt_valid_out (filt_valid_out),
    .filt_ready_out (filt_ready_out),
    .filt_q_w       (filt_q_w),
    .filt_q_x       (filt_q_x),
    .filt_q_y       (filt_q_y),
    .filt_q_z       (filt_q_z),
    .q_w            (q_w),
    .q_x            (q_x),
    .q_y            (q_y),
    .q_z            (q_z),
    .q_new          (q_new),
    .q_ack          (q_ack),
    .overrun        (overrun),
    .ovr_clr        (ovr_clr),
    .sample_cnt     (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the pending capture, the sample in flight and the host-visible status.
  logic [15:0] m_cap[6];
  bit          m_got[6];
  logic [15:0] m_filt[6];
  logic [15:0] m_q[4];
  bit          m_inflight, m_sent, m_qnew, m_ovr, m_on;
  int unsigned m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_cap[i]  = '0;
      m_got[i]  = 1'b0;
      m_filt[i] = '0;
    end
    for (int i = 0; i < 4; i++) m_q[i] = '0;
    m_inflight = 1'b0;
    m_sent     = 1'b0;
    m_qnew     = 1'b0;
    m_ovr      = 1'b0;
    m_cnt      = 0;
    m_on       = 1'b1;
  endtask

  function automatic bit m_full();
    for (int i = 0; i < 6; i++) if (!m_got[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [15:0] dut_filt[6];
    logic [15:0] dut_q[4];
    bit full, take, in_xfer, out_xfer, ovr_set;
    if (rst) model_reset();
    if (m_on) begin
      dut_filt[0] = filt_a_x; dut_filt[1] = filt_a_y; dut_filt[2] = filt_a_z;
      dut_filt[3] = filt_w_x; dut_filt[4] = filt_w_y; dut_filt[5] = filt_w_z;
      dut_q[0] = q_w; dut_q[1] = q_x; dut_q[2] = q_y; dut_q[3] = q_z;
      full = m_full();
      check_eq("s_ready", 32'(s_ready), 32'(!full));
      check_eq("filt_valid_in", 32'(filt_valid_in), 32'(m_inflight && !m_sent));
      check_eq("filt_ready_out", 32'(filt_ready_out), 32'(m_inflight && m_sent));
      for (int i = 0; i < 6; i++) check_eq("filt_data", 32'(dut_filt[i]), 32'(m_filt[i]));
      for (int i = 0; i < 4; i++) check_eq("q_data", 32'(dut_q[i]), 32'(m_q[i]));
      check_eq("q_new", 32'(q_new), 32'(m_qnew));
      check_eq("overrun", 32'(overrun), 32'(m_ovr));
      check_eq("sample_cnt", 32'(sample_cnt), m_cnt % (1 << CNT_W));
      if (!rst) begin
        take     = !m_inflight && full && enable;
        in_xfer  = m_inflight && !m_sent && filt_ready_in;
        out_xfer = m_inflight && m_sent && filt_valid_out;
        ovr_set  = out_xfer && m_qnew && !q_ack;
        if (s_valid && !full && s_axis < 3'd6) begin
          m_cap[s_axis] = s_data;
          m_got[s_axis] = 1'b1;
        end
        if (take) begin
          for (int i = 0; i < 6; i++) begin
            m_filt[i] = m_cap[i];
            m_got[i]  = 1'b0;
          end
          m_inflight = 1'b1;
          m_sent     = 1'b0;
        end
        if (in_xfer) m_sent = 1'b1;
        if (out_xfer) begin
          m_q[0] = filt_q_w; m_q[1] = filt_q_x; m_q[2] = filt_q_y; m_q[3] = filt_q_z;
          m_cnt++;
          m_qnew     = 1'b1;
          m_inflight = 1'b0;
        end else if (q_ack) begin
          m_qnew = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ax, input int d);
    s_valid = 1'b1;
    s_axis  = 3'(ax);
    s_data  = 16'(d);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_sample(input int base);
    for (int i = 0; i < 6; i++) send(i, base + i);
  endtask

  task automatic return_q(input int w, input int x, input int y, input int z, input bit ack);
    filt_valid_out = 1'b1;
    q_ack          = ack;
    filt_q_w = 16'(w); filt_q_x = 16'(x); filt_q_y = 16'(y); filt_q_z = 16'(z);
    tick();
    filt_valid_out = 1'b0;
    q_ack          = 1'b0;
  endtask

  initial begin
    int ord[7];
    int dat[7];
    ord = '{5, 3, 0, 1, 2, 2, 4};
    dat = '{50, 30, 10, 20, 7, 9, 40};

    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_s_ready", 32'(s_ready), 32'd1);
    check_eq("reset_cnt", 32'(sample_cnt), 32'd0);

    // In-order sample, values 1..6, filter always ready.
    enable = 1'b1;
    filt_ready_in = 1'b1;
    tick();
    send_sample(1);
    @(negedge clk);
    check_eq("t1_full", 32'(s_ready), 32'd0);
    check_eq("t1_no_issue_yet", 32'(filt_valid_in), 32'd0);
    tick();
    @(negedge clk);
    check_eq("t1_issue", 32'(filt_valid_in), 32'd1);
    check_eq("t1_a_x", 32'(filt_a_x), 32'd1);
    check_eq("t1_w_z", 32'(filt_w_z), 32'd6);
    check_eq("t1_ready_again", 32'(s_ready), 32'd1);
    tick();
    @(negedge clk);
    check_eq("t1_ready_out", 32'(filt_ready_out), 32'd1);
    repeat (40) tick();
    return_q(16'h4000, 0, 0, 0, 1'b0);
    @(negedge clk);
    check_eq("t1_q_w", 32'(q_w), 32'h4000);
    check_eq("t1_q_new", 32'(q_new), 32'd1);
    check_eq("t1_cnt", 32'(sample_cnt), 32'd1);
    q_ack = 1'b1;
    tick();
    q_ack = 1'b0;
    @(negedge clk);
    check_eq("t1_ack", 32'(q_new), 32'd0);

    // Out-of-order axes with a repeated a_z; filter stalls input.
    filt_ready_in = 1'b0;
    for (int i = 0; i < 7; i++) send(ord[i], dat[i]);
    tick();
    @(negedge clk);
    check_eq("t2_issue", 32'(filt_valid_in), 32'd1);
    check_eq("t2_a_z", 32'(filt_a_z), 32'd9);
    check_eq("t2_w_x", 32'(filt_w_x), 32'd30);
    filt_ready_in = 1'b1;
    tick();

    // Prefetch during WAIT_Q, then two results with no ack.
    send_sample(16'h100);
    @(negedge clk);
    check_eq("t3_prefetch_full", 32'(s_ready), 32'd0);
    tick();
    return_q(1, 2, 3, 4, 1'b0);
    @(negedge clk);
    check_eq("t3_q_new", 32'(q_new), 32'd1);
    tick();
    @(negedge clk);
    check_eq("t3_turnaround", 32'(filt_valid_in), 32'd1);
    check_eq("t3_a_x", 32'(filt_a_x), 32'h100);
    tick();
    return_q(5, 6, 7, 8, 1'b0);
    @(negedge clk);
    check_eq("t3_overrun", 32'(overrun), 32'd1);
    check_eq("t3_q_w", 32'(q_w), 32'd5);
    check_eq("t3_cnt", 32'(sample_cnt), 32'd3);

    // Latch coinciding with ack.
    send_sample(16'h200);
    repeat (3) tick();
    return_q(9, 10, 11, 12, 1'b1);
    @(negedge clk);
    check_eq("t4_q_new", 32'(q_new), 32'd1);
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    tick();
    ovr_clr = 1'b1;
    q_ack   = 1'b1;
    tick();
    ovr_clr = 1'b0;
    q_ack   = 1'b0;
    @(negedge clk);
    check_eq("t4_ovr_clr", 32'(overrun), 32'd0);

    // enable low holds a full capture in IDLE.
    enable = 1'b0;
    filt_ready_in = 1'b0;
    send_sample(16'h300);
    repeat (10) tick();
    @(negedge clk);
    check_eq("t5_hold", 32'(filt_valid_in), 32'd0);
    tick();
    enable = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t5_release", 32'(filt_valid_in), 32'd1);

    // Reset during ISSUE with three axes pending.
    tick();
    send(0, 16'h11);
    send(1, 16'h22);
    send(2, 16'h33);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_valid_in", 32'(filt_valid_in), 32'd0);
    check_eq("t6_s_ready", 32'(s_ready), 32'd1);
    check_eq("t6_cnt", 32'(sample_cnt), 32'd0);
    check_eq("t6_a_x", 32'(filt_a_x), 32'd0);
    tick();
    rst = 1'b0;
    filt_ready_in = 1'b1;
    send_sample(16'h400);
    repeat (3) tick();
    return_q(16'h1234, 1, 2, 3, 1'b0);
    @(negedge clk);
    check_eq("t6_cnt_after", 32'(sample_cnt), 32'd1);
    check_eq("t6_q_w", 32'(q_w), 32'h1234);

    // Random traffic; sample_cnt wraps several times at CNT_W=4.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst            = ($urandom_range(0, 799) == 0);
      s_valid        = ($urandom_range(0, 3) != 0);
      s_axis         = 3'($urandom_range(0, 7));
      s_data         = 16'($urandom);
      enable         = ($urandom_range(0, 7) != 0);
      filt_ready_in  = ($urandom_range(0, 1) != 0);
      filt_valid_out = ($urandom_range(0, 2) == 0);
      filt_q_w       = 16'($urandom);
      filt_q_x       = 16'($urandom);
      filt_q_y       = 16'($urandom);
      filt_q_z       = 16'($urandom);
      q_ack          = ($urandom_range(0, 3) == 0);
      ovr_clr        = ($urandom_range(0, 15) == 0);
    end
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    filt_valid_out = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imu_sample_feeder.md
# imu_sample_feeder

Hardware initiator for the `madgwick` filter: collects six raw IMU axis words from the upstream sensor reader and issues each complete sample on the filter's input valid/ready handshake. It then drains the resulting normalised quaternion on the output handshake and holds it, with a new-data flag and sample counter, for the attitude_sensor register interface. It sits between the sensor reader and `madgwick`, replacing bench-driven stimulus in the SweRVolf attitude peripheral.

## Interface
- `DATA_W`, 16: upstream axis word width
- `ACC_W`, 16: accelerometer width; top level passes `ACC_WIDTH`
- `GYRO_W`, 16: gyro width; top level passes `GYRO_WIDTH`
- `Q_W`, 16: quaternion component width; top level passes `Q_WIDTH`
- `CNT_W`, 16: sample counter width

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `enable` in 1: permits starting new samples
- `s_valid` in 1, `s_ready` out 1: upstream axis-word handshake
- `s_axis` in 3: axis index 0..5 = a_x, a_y, a_z, w_x, w_y, w_z; values 6 and 7 are discarded
- `s_data` in DATA_W: signed axis word; low ACC_W/GYRO_W bits are kept
- `filt_valid_in` out 1, `filt_ready_in` in 1: filter input handshake
- `filt_a_x`, `filt_a_y`, `filt_a_z` out ACC_W; `filt_w_x`, `filt_w_y`, `filt_w_z` out GYRO_W: issued sample
- `filt_valid_out` in 1, `filt_ready_out` out 1: filter output handshake
- `filt_q_w`/`x`/`y`/`z` in Q_W: filter quaternion
- `q_w`/`q_x`/`q_y`/`q_z` out Q_W: latched quaternion
- `q_new` out 1: unread quaternion present
- `q_ack` in 1: host read strobe; clears `q_new`
- `overrun` out 1: sticky flag; a quaternion was overwritten before it was acknowledged
- `ovr_clr` in 1: clears `overrun`
- `sample_cnt` out CNT_W: count of completed quaternions; wraps modulo 2^CNT_W

## Operation
- Capture stage: a 6-bit received mask plus a capture register per axis. A word is accepted when `s_valid && s_ready`. The word writes its axis and sets its mask bit. A repeat axis before completion overwrites the value; the mask is unchanged.
- `s_ready = !cap_full`, where `cap_full` = all six mask bits set. Index 6/7 words are accepted and dropped.
- FSM states `IDLE`, `ISSUE`, `WAIT_Q`:
  - `IDLE`: if `cap_full && enable`, copy the capture registers to the `filt_*` output registers, clear the mask, and go to `ISSUE`.
  - `ISSUE`: `filt_valid_in=1`; the `filt_*` registers are stable. On `filt_ready_in`, go to `WAIT_Q`.
  - `WAIT_Q`: `filt_ready_out=1`. On `filt_valid_out`, latch `filt_q_*` into `q_*`, set `q_new`, increment `sample_cnt`, and go to `IDLE`.
- Capture stays open during `ISSUE`/`WAIT_Q`, so the next sample prefetches (double buffering).
- `enable` low only blocks leaving `IDLE`; an in-flight sample completes.
- `q_ack` clears `q_new`. If a quaternion latch and `q_ack` occur in the same cycle, the latch wins (`q_new` stays 1) and no overrun is flagged.
- `overrun` sets on a latch while `q_new=1` without `q_ack` in that cycle. If `ovr_clr` and a set event coincide, the set wins.

## Timing
- Reset values: FSM `IDLE`, mask 0; `s_ready=1`; `filt_valid_in=0`; `filt_ready_out=0`; `filt_*`, `q_*`, `sample_cnt` = 0; `q_new=0`; `overrun=0`.
- All outputs are registered or decoded directly from state.
- Last axis word accepted in cycle N:
  - `cap_full` and `s_ready=0` at N+1.
  - `filt_valid_in=1` from N+2 if the FSM is `IDLE` and `enable` is high.
  - `s_ready=1` again from N+2.
- The input transfer completes in the cycle where `filt_valid_in && filt_ready_in`; `filt_ready_out=1` from the next cycle.
- Output transfer in cycle M: `q_*`, `q_new`, `sample_cnt` update at M+1, and `filt_ready_out=0` at M+1.
- Minimum sample turnaround, back-to-back with a prefetched capture: `filt_valid_in` is high 2 cycles after the output transfer.
- `rst` asserted mid-transaction drops `filt_valid_in`/`filt_ready_out` immediately and discards the partial capture. A filter result arriving later is not consumed; the filter is reset from the same `rst`.
- `sample_cnt` wraps from 2^CNT_W-1 to 0 with no flag.

## Structure
- Shared package `attitude_pkg`:
  - FSM state enum `feeder_state_t`
  - axis index constants `AXIS_AX`..`AXIS_WZ`
  - `AXIS_ALL = 6'b111111`
- One sub-module, `imu_sample_capture`: the mask, the capture registers, and `s_ready`/`cap_full`. It exposes a `take` strobe that clears the mask.
- The FSM and the quaternion latch stay in the top level.

## Test plan
- Six words, axes 0..5, values 1..6, `filt_ready_in` tied high → `filt_valid_in` asserted 2 cycles after the last word with a_x=1 … w_z=6. `filt_ready_out` high the next cycle.
- Out-of-order axes 5,3,0,1,2,4, with axis 2 sent twice (7 then 9) → issued a_z=9, and no issue before the sixth distinct axis.
- Filter returns q=(0x4000,0,0,0) with `filt_valid_out` delayed 40 cycles → `q_w=0x4000`, `q_new=1`, `sample_cnt=1`. `q_ack` clears `q_new` the next cycle.
- Two quaternions with no `q_ack` → `overrun=1` and `q_*` holds the second value. Latch coinciding with `q_ack` → `q_new=1`, `overrun` unchanged.
- Second sample streamed during `WAIT_Q` → capture full and `s_ready=0`; the second `filt_valid_in` follows 2 cycles after the first output transfer. `enable=0` holds it in `IDLE` until re-enabled.
- `rst` pulsed during `ISSUE` with 3 axes pending → all outputs at reset values the same cycle; a new full sample then completes normally with `sample_cnt=1`.
